// File: rtl/hdc_pkg.sv
// Shared types, constants and helpers for the streaming HDC encoder.
// The hypervector width here sets the default dimension of the encoder.
package hdc_pkg;

  localparam int          HDC_D        = 1024;
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {INIT, IDLE, ACCUM, DRAIN, THRESH, OUT} state_t;

  typedef logic [HDC_D-1:0] hv_t;

  function automatic hv_t rotl_hv(hv_t hv, int unsigned k);
    return (hv << k) | (hv >> (HDC_D - k));
  endfunction

  // Right-shifting Fibonacci LFSR; the feedback bit enters at the top.
  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/hdc_lfsr_gen.sv
// Pseudo-random bit source for base hypervector generation.
// Produces GEN_W LFSR output bits per enabled cycle; load restarts from the seed.
module hdc_lfsr_gen
  import hdc_pkg::*;
#(
  parameter int GEN_W = 64
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [15:0]      seed,
  output logic [GEN_W-1:0] gen_bits
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // A zero seed would lock the LFSR, so it is replaced by the default.
  always_comb begin
    logic [15:0] walk;
    walk     = load ? ((seed == 16'h0000) ? DEFAULT_SEED : seed) : lfsr_q;
    gen_bits = '0;
    for (int j = 0; j < GEN_W; j++) begin
      walk        = lfsr_step(walk);
      gen_bits[j] = walk[0];
    end
    lfsr_d = enable ? walk : lfsr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= DEFAULT_SEED;
    else     lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/hdc_stream_encoder.sv
// Streaming record-based HDC encoder: binds rotated position HVs with level HVs
// per feature beat, bundles them in per-dimension counters and emits the majority HV.
module hdc_stream_encoder
  import hdc_pkg::*;
#(
  parameter int D        = HDC_D,
  parameter int FEATURES = 16,
  parameter int LEVELS   = 16,
  parameter int GEN_W    = 64,
  parameter int CW       = $clog2(FEATURES + 1),
  parameter int LW       = $clog2(LEVELS)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   seed_lfsr,
  input  logic          init_req,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [LW-1:0] in_level,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [D-1:0]  out_hv,
  output logic          overflow
);

  localparam int            CHUNKS    = D / GEN_W;
  localparam int            IW        = $clog2(2 * CHUNKS);
  localparam int            FLIP_STEP = D / (2 * (LEVELS - 1));
  localparam logic [IW-1:0] INIT_LAST = IW'(2 * CHUNKS - 1);
  localparam logic [CW-1:0] FEAT_LAST = CW'(FEATURES - 1);

  state_t                 state_q, state_d;
  logic [IW-1:0]          init_cnt_q, init_cnt_d;
  logic [D-1:0]           p_base_q, p_base_d;
  logic [D-1:0]           l_base_q, l_base_d;
  logic [D-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]          feat_idx_q, feat_idx_d;
  logic                   overflow_q, overflow_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [D-1:0]           out_hv_q, out_hv_d;

  logic                   gen_load, gen_en;
  logic [GEN_W-1:0]       gen_bits;
  logic [LW-1:0]          q_level;
  logic [D-1:0]           lvl_mask;
  logic [D-1:0]           bound_hv;
  logic                   accept;
  int                     chunk;

  hdc_lfsr_gen #(.GEN_W(GEN_W)) u_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (gen_load),
    .enable   (gen_en),
    .seed     (seed_lfsr),
    .gen_bits (gen_bits)
  );

  if ((1 << LW) > LEVELS) begin : g_clamp
    assign q_level = (in_level > LW'(LEVELS - 1)) ? LW'(LEVELS - 1) : in_level;
  end else begin : g_noclamp
    assign q_level = in_level;
  end

  // Level HV = L_base with its lowest q*FLIP_STEP bits inverted.
  always_comb begin
    int thr;
    thr = int'(q_level) * FLIP_STEP;
    lvl_mask = '0;
    for (int i = 0; i < D; i++) lvl_mask[i] = (i < thr);
    bound_hv = rotl_hv(p_base_q, 32'(feat_idx_q)) ^ l_base_q ^ lvl_mask;
  end

  always_comb begin
    logic [CW:0] two_cnt;
    logic [CW:0] n_ext;
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    p_base_d   = p_base_q;
    l_base_d   = l_base_q;
    cnt_d      = cnt_q;
    feat_idx_d = feat_idx_q;
    overflow_d = overflow_q;
    out_hv_d   = out_hv_q;
    gen_en     = 1'b0;
    gen_load   = 1'b0;
    accept     = 1'b0;
    chunk      = 0;
    two_cnt    = '0;
    n_ext      = {1'b0, feat_idx_q};

    case (state_q)
      INIT: begin
        gen_en   = 1'b1;
        gen_load = (init_cnt_q == '0);
        if (init_cnt_q < IW'(CHUNKS)) begin
          chunk = int'(init_cnt_q);
          p_base_d[chunk*GEN_W +: GEN_W] = gen_bits;
        end else begin
          chunk = int'(init_cnt_q) - CHUNKS;
          l_base_d[chunk*GEN_W +: GEN_W] = gen_bits;
        end
        init_cnt_d = init_cnt_q + IW'(1);
        if (init_cnt_q == INIT_LAST) begin
          init_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      // A regeneration request takes priority over a beat presented in the same cycle.
      IDLE: begin
        if (init_req) begin
          state_d    = INIT;
          init_cnt_d = '0;
          overflow_d = 1'b0;
        end else begin
          accept = in_valid;
        end
      end
      ACCUM:  accept = in_valid;
      DRAIN:  if (in_valid && in_last) state_d = THRESH;
      THRESH: begin
        for (int i = 0; i < D; i++) begin
          two_cnt     = {cnt_q[i], 1'b0};
          out_hv_d[i] = (two_cnt > n_ext) | ((two_cnt == n_ext) & p_base_q[i]);
        end
        cnt_d      = '0;
        feat_idx_d = '0;
        state_d    = OUT;
      end
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = INIT;
    endcase

    if (accept) begin
      for (int i = 0; i < D; i++) cnt_d[i] = cnt_q[i] + CW'(bound_hv[i]);
      feat_idx_d = feat_idx_q + CW'(1);
      if (in_last) begin
        state_d = THRESH;
      end else if (feat_idx_q == FEAT_LAST) begin
        state_d    = DRAIN;
        overflow_d = 1'b1;
      end else begin
        state_d = ACCUM;
      end
    end

    in_ready_d  = (state_d == IDLE) || (state_d == ACCUM) || (state_d == DRAIN);
    out_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      p_base_q    <= '0;
      l_base_q    <= '0;
      cnt_q       <= '0;
      feat_idx_q  <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_hv_q    <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      p_base_q    <= p_base_d;
      l_base_q    <= l_base_d;
      cnt_q       <= cnt_d;
      feat_idx_q  <= feat_idx_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_hv_q    <= out_hv_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_hv    = out_hv_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_hdc_stream_encoder.sv
// Directed self-checking bench for hdc_stream_encoder with a bit-level golden model
// of the LFSR base generation, binding and majority bundling.
module tb_hdc_stream_encoder;

  localparam int D        = 1024;
  localparam int FEATURES = 16;
  localparam int LEVELS   = 16;
  localparam int GEN_W    = 64;
  localparam int LW       = 4;
  localparam int FLIP     = D / (2 * (LEVELS - 1));

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   seed_lfsr = 16'h0000;
  logic          init_req = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] in_level = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [D-1:0]  out_hv;
  logic          overflow;

  hdc_stream_encoder #(
    .D(D), .FEATURES(FEATURES), .LEVELS(LEVELS), .GEN_W(GEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_lfsr (seed_lfsr),
    .init_req  (init_req),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_level  (in_level),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hv    (out_hv),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           beat_cyc = 0;
  logic [D-1:0] mp, ml, exp_hv;
  int           acc [D];
  int           acc_n;
  int           stim_lv [$];
  logic [D-1:0] out_q [$];
  int           out_cyc_q [$];
  logic [D-1:0] exp_q [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      out_q.push_back(out_hv);
      out_cyc_q.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkHv(input string tag, input logic [D-1:0] obs, input logic [D-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed[63:0]=%h expected[63:0]=%h differing_bits=%0d",
             tag, obs[63:0], expv[63:0], $countones(obs ^ expv));
    end
  endtask

  task automatic genBases(input logic [15:0] seed);
    logic [15:0] s;
    logic        fb;
    s = (seed == 16'h0000) ? 16'hACE1 : seed;
    for (int k = 0; k < 2 * D; k++) begin
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      s  = {fb, s[15:1]};
      if (k < D) mp[k] = s[0];
      else       ml[k - D] = s[0];
    end
  endtask

  function automatic logic [D-1:0] bindHv(input int level, input int idx);
    logic [D-1:0] r;
    int           q;
    q = (level > LEVELS - 1) ? LEVELS - 1 : level;
    for (int i = 0; i < D; i++)
      r[i] = mp[(i - idx + D) % D] ^ ml[i] ^ (i < q * FLIP);
    return r;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < D; i++) acc[i] = 0;
    acc_n = 0;
  endtask

  task automatic modelAdd(input int level, input int idx);
    logic [D-1:0] b;
    b = bindHv(level, idx);
    for (int i = 0; i < D; i++) acc[i] += int'(b[i]);
    acc_n++;
  endtask

  task automatic modelResult();
    for (int i = 0; i < D; i++) begin
      if (2 * acc[i] > acc_n)       exp_hv[i] = 1'b1;
      else if (2 * acc[i] == acc_n) exp_hv[i] = mp[i];
      else                          exp_hv[i] = 1'b0;
    end
  endtask

  // Presents one beat and returns just after the clock edge that accepted it.
  task automatic applyStimulus(input int level, input bit last);
    bit rdy;
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_level = level[LW-1:0];
    in_last  = last;
    for (int k = 0; k < 200 && !accepted; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) accepted = 1'b1;
    end
    beat_cyc = cyc - 1;
    total++;
    assert (accepted) else begin
      bad++;
      $error("[TB] FAIL accept_timeout: observed=not accepted expected=accepted (level %0d)", level);
    end
  endtask

  task automatic runSample(input bit hold);
    modelClear();
    for (int i = 0; i < stim_lv.size(); i++) begin
      applyStimulus(stim_lv[i], (i == stim_lv.size() - 1));
      if (i < FEATURES) modelAdd(stim_lv[i], i);
    end
    if (!hold) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    modelResult();
  endtask

  task automatic waitInReady(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic popOutput(output logic [D-1:0] hv, output int c);
    for (int k = 0; k < 200 && out_q.size() == 0; k++) @(negedge clk);
    total++;
    assert (out_q.size() > 0) else begin
      bad++;
      $error("[TB] FAIL out_timeout: observed=no output expected=one output");
    end
    if (out_q.size() > 0) begin
      hv = out_q.pop_front();
      c  = out_cyc_q.pop_front();
    end else begin
      hv = '0;
      c  = -100;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [D-1:0] hv;
    int           n;
    int           oc;

    // Reset values
    #1 rst = 1'b1;
    out_ready = 1'b1;
    #20;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkHv("rst_out_hv", out_hv, '0);

    // Base generation after reset with seed 0
    @(posedge clk);
    #1 rst = 1'b0;
    waitInReady(n);
    checkOutput("init_cycles", n, 32);
    genBases(16'h0000);
    checkHv("p_base", dut.p_base_q, mp);
    checkHv("l_base", dut.l_base_q, ml);

    // Single beat at level 0: the output is P_base ^ L_base
    stim_lv = '{0};
    runSample(1'b0);
    popOutput(hv, oc);
    checkHv("one_beat_hv", hv, mp ^ ml);
    checkOutput("one_beat_latency", oc - beat_cyc, 2);

    // Three beats, majority without ties
    stim_lv = '{0, 15, 0};
    runSample(1'b0);
    popOutput(hv, oc);
    checkHv("three_beat_hv", hv, exp_hv);

    // Two beats (ties broken by P_base) and output held under backpressure
    @(posedge clk);
    #1 out_ready = 1'b0;
    stim_lv = '{0, 15};
    runSample(1'b0);
    for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
    checkOutput("hold_valid", out_valid, 1);
    checkHv("two_beat_hv", out_hv, exp_hv);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkHv("hold_stable", out_hv, exp_hv);
      checkOutput("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("post_ack_in_ready", in_ready, 1);
    checkOutput("post_ack_out_valid", out_valid, 0);
    out_q.delete();
    out_cyc_q.delete();
    @(posedge clk);
    #1;

    // Twenty beats: implicit last at beat 16, beats 17-20 dropped
    stim_lv.delete();
    for (int i = 0; i < 20; i++) stim_lv.push_back((i * 7) % 16);
    runSample(1'b0);
    popOutput(hv, oc);
    checkHv("overflow_hv", hv, exp_hv);
    checkOutput("overflow_single_out", out_q.size(), 0);
    checkOutput("overflow_set", overflow, 1);

    // init_req with a new seed clears overflow and regenerates the bases
    seed_lfsr = 16'h1234;
    init_req  = 1'b1;
    @(posedge clk);
    #1 init_req = 1'b0;
    checkOutput("init_clears_overflow", overflow, 0);
    checkOutput("init_in_ready", in_ready, 0);
    waitInReady(n);
    checkOutput("reinit_cycles", n, 32);
    genBases(16'h1234);
    checkHv("p_base_seeded", dut.p_base_q, mp);
    checkHv("l_base_seeded", dut.l_base_q, ml);

    // Reset during the third beat of a sample
    applyStimulus(3, 1'b0);
    applyStimulus(8, 1'b0);
    in_valid = 1'b1;
    in_level = 4'd5;
    in_last  = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_overflow", overflow, 0);
    checkHv("midrst_out_hv", out_hv, '0);
    checkOutput("midrst_feat_idx", dut.feat_idx_q, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    waitInReady(n);
    checkOutput("rst_reinit_cycles", n, 32);
    genBases(16'h1234);
    checkHv("p_base_after_rst", dut.p_base_q, mp);
    stim_lv = '{9};
    runSample(1'b0);
    popOutput(hv, oc);
    checkHv("post_reset_hv", hv, exp_hv);

    // Back-to-back samples with in_valid held high
    stim_lv = '{2, 5};
    runSample(1'b1);
    exp_q.push_back(exp_hv);
    stim_lv = '{7};
    runSample(1'b1);
    exp_q.push_back(exp_hv);
    stim_lv = '{15, 1, 4};
    runSample(1'b0);
    exp_q.push_back(exp_hv);
    for (int k = 0; k < 3; k++) begin
      popOutput(hv, oc);
      checkHv($sformatf("b2b_hv%0d", k), hv, exp_q[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
